// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered multi-op ALU with start/busy/done handshake
//
// Two WIDTH-bit operands and an opcode are captured on accept. Concat, add,
// subtract and BCD add finish one cycle after accept. Multiply runs an
// iterative shift-add over WIDTH cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted only in IDLE
//   a, b   WIDTH-bit operands
//   sel    3-bit opcode (000 concat, 001 add, 010 sub, 011 bcd add, 100 mul)
//   busy   operation in flight (low in the done cycle)
//   done   one-cycle pulse when y/cout/err are fresh
//   y      2*WIDTH-bit result, held between done pulses
//   cout   carry / borrow / BCD carry
//   err    illegal opcode or non-BCD operand digit
module seq_alu #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [2:0]           sel,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   y,
   output logic                 cout,
   output logic                 err
);

   localparam int NDIG = WIDTH / 4;
   localparam int CW   = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;      // also the multiplier shift register
   logic [2:0]         sel_q;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic               accept;
   logic               mul_last;
   logic [WIDTH:0]     mul_sum;

   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     sub_d;
   logic [WIDTH-1:0]   bcd_sum;
   logic               bcd_c;
   logic               bcd_bad;
   logic [4:0]         dig_s;

   logic [2*WIDTH-1:0] exec_y;
   logic               exec_cout;
   logic               exec_err;

   assign accept   = start && (state == IDLE);
   // The cycle after the last shift-add step only transfers acc to y.
   assign mul_last = (cnt == CW'(WIDTH));

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == EXEC) || (state_nxt == MUL);
         done  <= (state_nxt == DONE);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (sel == 3'b100) ? MUL : EXEC;
            end
         end
         EXEC: state_nxt = DONE;
         MUL: begin
            if (mul_last) begin
               state_nxt = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- single-cycle datapath ----------------
   // The extra top bit of the subtraction is the borrow (A < B).
   assign add_s = {1'b0, a_q} + {1'b0, b_q};
   assign sub_d = {1'b0, a_q} - {1'b0, b_q};

   always_comb begin
      bcd_c   = 1'b0;
      bcd_bad = 1'b0;
      bcd_sum = '0;
      dig_s   = '0;
      for (int d = 0; d < NDIG; d++) begin
         dig_s = {1'b0, a_q[4*d +: 4]} + {1'b0, b_q[4*d +: 4]} + {4'b0, bcd_c};
         if (dig_s > 5'd9) begin
            dig_s = dig_s + 5'd6;
            bcd_c = 1'b1;
         end else begin
            bcd_c = 1'b0;
         end
         bcd_sum[4*d +: 4] = dig_s[3:0];
         if ((a_q[4*d +: 4] > 4'd9) || (b_q[4*d +: 4] > 4'd9)) begin
            bcd_bad = 1'b1;
         end
      end
   end

   always_comb begin
      exec_y    = '0;
      exec_cout = 1'b0;
      exec_err  = 1'b0;
      case (sel_q)
         3'b000: exec_y = {a_q, b_q};
         3'b001: begin
            exec_y    = {{(WIDTH-1){1'b0}}, add_s};
            exec_cout = add_s[WIDTH];
         end
         3'b010: begin
            exec_y    = {{(WIDTH-1){1'b0}}, sub_d};
            exec_cout = sub_d[WIDTH];
         end
         3'b011: begin
            exec_y    = {{(WIDTH-1){1'b0}}, bcd_c, bcd_sum};
            exec_cout = bcd_c;
            exec_err  = bcd_bad;
         end
         default: exec_err = 1'b1;
      endcase
   end

   // ---------------- shift-add multiplier ----------------
   // Right-shifting accumulator: the upper half absorbs the multiplicand when
   // the current multiplier bit is set; the WIDTH+1 sum never overflows.
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         sel_q <= '0;
         acc   <= '0;
         cnt   <= '0;
         y     <= '0;
         cout  <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sel_q <= sel;
            acc   <= '0;
            cnt   <= '0;
         end
         if (state == MUL && !mul_last) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            b_q <= b_q >> 1;
            cnt <= cnt + CW'(1);
         end
         // Result registers change only on the edge that raises done.
         if (state == EXEC) begin
            y    <= exec_y;
            cout <= exec_cout;
            err  <= exec_err;
         end else if (state == MUL && mul_last) begin
            y    <= acc;
            cout <= 1'b0;
            err  <= 1'b0;
         end
      end
   end

endmodule
